dual_issue_dispatcher: RTL and testbench

- Issue stage directly upstream of the register-management block in the dual-issue microcontroller.
- Buffers decoded instructions in a small FIFO and checks register hazards against processing_register_table plus a one-cycle local shadow.
- Selects an idle processor, hands it the instruction with a valid/accept handshake, and pulses the matching boot_renew_register_x with the destination register number.
- Instructions flagged as sync-barrier wait for synchronized_processors before issue.

---
 rtl/dual_issue_dispatcher.sv | 127 ++++++++++++
 tb/tb_dual_issue_dispatcher.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_dispatcher.sv
// dual_issue_dispatcher: buffers decoded instructions, screens register hazards and
// hands each head instruction to an idle processor with a writeback-claim pulse.
module dual_issue_dispatcher #(
    parameter int REGISTER_AMOUNT   = 32,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int FIFO_DEPTH        = 4,
    parameter int REG_CTN_WIDTH     = $clog2(REGISTER_AMOUNT)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INSTRUCTION_WIDTH-1:0] in_instr,
    input  logic [REG_CTN_WIDTH-1:0]     in_rd,
    input  logic [REG_CTN_WIDTH-1:0]     in_rs1,
    input  logic [REG_CTN_WIDTH-1:0]     in_rs2,
    input  logic                         in_sync,
    input  logic                         processor_idle_1,
    input  logic                         processor_idle_2,
    input  logic [REGISTER_AMOUNT-1:0]   processing_register_table,
    input  logic                         synchronized_processors,
    output logic                         issue_valid_1,
    output logic                         issue_valid_2,
    output logic [INSTRUCTION_WIDTH-1:0] issue_instr_1,
    output logic [INSTRUCTION_WIDTH-1:0] issue_instr_2,
    output logic                         boot_renew_register_1,
    output logic                         boot_renew_register_2,
    output logic [REG_CTN_WIDTH-1:0]     register_num,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [INSTRUCTION_WIDTH-1:0] instr;
        logic [REG_CTN_WIDTH-1:0]     rd;
        logic [REG_CTN_WIDTH-1:0]     rs1;
        logic [REG_CTN_WIDTH-1:0]     rs2;
        logic                         sync;
    } entry_t;

    typedef enum logic [1:0] {IDLE, BARRIER, OFFER1, OFFER2} state_t;

    state_t                   state, state_nx;
    entry_t                   mem [FIFO_DEPTH];
    entry_t                   head;
    logic [PW-1:0]            wr_ptr, rd_ptr;
    logic [CW-1:0]            count;
    logic [REG_CTN_WIDTH-1:0] shadow_rd;
    logic                     shadow_valid, busy_1, busy_2;
    logic                     push, accept, boot, hazard, sel_1, sel_2, barrier_ok;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic reg_haz(input logic [REG_CTN_WIDTH-1:0] r,
                                     input logic [REGISTER_AMOUNT-1:0] tbl,
                                     input logic sv, input logic [REG_CTN_WIDTH-1:0] sr);
        return r != '0 && (tbl[r] || (sv && sr == r));
    endfunction

    assign head       = mem[rd_ptr];
    assign in_ready   = count != CW'(FIFO_DEPTH);
    assign fifo_count = count;
    assign push       = in_valid && in_ready;
    assign hazard     = reg_haz(head.rd, processing_register_table, shadow_valid, shadow_rd)
                     || reg_haz(head.rs1, processing_register_table, shadow_valid, shadow_rd)
                     || reg_haz(head.rs2, processing_register_table, shadow_valid, shadow_rd);
    assign sel_1      = processor_idle_1 && !busy_1;
    assign sel_2      = processor_idle_2 && !busy_2 && head.rd != REG_CTN_WIDTH'(1);
    assign barrier_ok = processor_idle_1 && processor_idle_2 && synchronized_processors
                     && processing_register_table == '0 && !shadow_valid;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (count != '0 && !hazard)
                         state_nx = head.sync ? BARRIER : sel_1 ? OFFER1 : sel_2 ? OFFER2 : IDLE;
            BARRIER: if (barrier_ok) state_nx = OFFER1;
            OFFER1:  if (!processor_idle_1) state_nx = IDLE;
            OFFER2:  if (!processor_idle_2) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A processor accepts by dropping its idle flag while it is being offered.
    always_comb begin
        issue_valid_1         = state == OFFER1;
        issue_valid_2         = state == OFFER2;
        issue_instr_1         = issue_valid_1 ? head.instr : '0;
        issue_instr_2         = issue_valid_2 ? head.instr : '0;
        accept                = (issue_valid_1 && !processor_idle_1) || (issue_valid_2 && !processor_idle_2);
        boot                  = accept && head.rd != '0;
        boot_renew_register_1 = boot && issue_valid_1;
        boot_renew_register_2 = boot && issue_valid_2;
        register_num          = boot ? head.rd : '0;
    end

    always_ff @(posedge clk)
        if (push)
            mem[wr_ptr] <= '{in_instr, in_rd, in_rs1, in_rs2, in_sync};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            shadow_valid <= 1'b0;
            shadow_rd    <= '0;
            busy_1       <= 1'b0;
            busy_2       <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (accept)
                rd_ptr <= rd_ptr + 1'b1;
            count        <= count + CW'(push) - CW'(accept);
            shadow_valid <= boot;
            shadow_rd    <= boot ? head.rd : shadow_rd;
            busy_1       <= (accept && issue_valid_1) || (busy_1 && !processor_idle_1);
            busy_2       <= (accept && issue_valid_2) || (busy_2 && !processor_idle_2);
        end
endmodule

// File: tb/tb_dual_issue_dispatcher.sv
// tb_dual_issue_dispatcher: vector table, directed corner sequences and a randomized
// run scored against a queue-based model of the dispatcher's issue rules.
module tb_dual_issue_dispatcher;
    localparam int FD = 4;

    logic        clk = 0, rst_n = 0;
    logic        in_valid, in_ready, in_sync, idle1, idle2, sync_proc;
    logic [31:0] in_instr, tbl, issue_instr_1, issue_instr_2;
    logic [4:0]  in_rd, in_rs1, in_rs2, register_num;
    logic        issue_valid_1, issue_valid_2, boot1, boot2;
    logic [2:0]  fifo_count;
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    dual_issue_dispatcher dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_sync(in_sync),
        .processor_idle_1(idle1), .processor_idle_2(idle2),
        .processing_register_table(tbl), .synchronized_processors(sync_proc),
        .issue_valid_1(issue_valid_1), .issue_valid_2(issue_valid_2),
        .issue_instr_1(issue_instr_1), .issue_instr_2(issue_instr_2),
        .boot_renew_register_1(boot1), .boot_renew_register_2(boot2),
        .register_num(register_num), .fifo_count(fifo_count)
    );

    typedef struct packed {
        logic        i1, i2;
        logic [31:0] t;
        logic        sp, sy;
        logic [4:0]  rd, rs1, rs2;
        logic        e1, e2;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd, rs1, rs2;
        logic        sync;
    } ent_t;

    vec_t vecs [13];
    ent_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 0; in_valid = 0; in_instr = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_sync = 0;
        idle1 = 1; idle2 = 1; tbl = 0; sync_proc = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic push(input logic [31:0] ins, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic sy);
        in_valid = 1; in_instr = ins; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_sync = sy;
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic wait_offer(input int k, input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (k == 1 ? issue_valid_1 : issue_valid_2) break;
        end
        check(name, 32'(i < budget), 1);
    endtask

    function automatic logic haz(input logic [4:0] r, input logic [31:0] t, input logic bv, input logic [4:0] br);
        return r != 0 && (t[r] || (bv && br == r));
    endfunction

    initial begin
        int pt1, pt2, issued;
        int ttim [32];
        logic [31:0] tbl_h1;
        logic i1_h1, i1_h2, i2_h1, sp_h1, bv_h1, bv_h2, pv, a1, a2, push_ok;
        logic [4:0] br_h1, br_h2;
        ent_t e;

        do_reset();
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_fifo_count", fifo_count, 0);
        check("reset_valids", {issue_valid_1, issue_valid_2, boot1, boot2}, 0);

        // idle1, idle2, table, sync_proc, sync, rd, rs1, rs2, expect proc1, expect proc2
        vecs[0]  = '{1, 1, 32'h0,      0, 0, 5, 2, 3, 1, 0};
        vecs[1]  = '{0, 1, 32'h0,      0, 0, 5, 2, 3, 0, 1};
        vecs[2]  = '{0, 0, 32'h0,      0, 0, 5, 2, 3, 0, 0};
        vecs[3]  = '{1, 1, 32'h20,     0, 0, 5, 2, 3, 0, 0};
        vecs[4]  = '{1, 1, 32'h8,      0, 0, 5, 2, 3, 0, 0};
        vecs[5]  = '{1, 1, 32'h1,      0, 0, 0, 0, 0, 1, 0};
        vecs[6]  = '{0, 1, 32'h0,      0, 0, 1, 2, 3, 0, 0};
        vecs[7]  = '{1, 1, 32'h0,      0, 0, 1, 2, 3, 1, 0};
        vecs[8]  = '{1, 1, 32'h0,      0, 1, 4, 2, 3, 0, 0};
        vecs[9]  = '{1, 1, 32'h0,      1, 1, 4, 2, 3, 1, 0};
        vecs[10] = '{1, 0, 32'h0,      1, 1, 4, 2, 3, 0, 0};
        vecs[11] = '{1, 1, 32'h200,    1, 1, 4, 2, 3, 0, 0};
        vecs[12] = '{1, 1, 32'h80,     0, 0, 5, 2, 3, 1, 0};
        for (int v = 0; v < 13; v++) begin
            do_reset();
            idle1 = vecs[v].i1; idle2 = vecs[v].i2; tbl = vecs[v].t; sync_proc = vecs[v].sp;
            push(32'hA000 + 32'(v), vecs[v].rd, vecs[v].rs1, vecs[v].rs2, vecs[v].sy);
            repeat (2) @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_valid1", v), issue_valid_1, vecs[v].e1);
            check($sformatf("vec%0d_valid2", v), issue_valid_2, vecs[v].e2);
            check($sformatf("vec%0d_count", v), fifo_count, 1);
            if (vecs[v].e1)
                check($sformatf("vec%0d_instr1", v), issue_instr_1, 32'hA000 + 32'(v));
            if (vecs[v].e2)
                check($sformatf("vec%0d_instr2", v), issue_instr_2, 32'hA000 + 32'(v));
        end

        // single add: offer, accept, one boot pulse
        do_reset();
        push(32'h0031_02B3, 5, 2, 3, 0);
        wait_offer(1, 5, "a_offer");
        check("a_count1", fifo_count, 1);
        check("a_instr", issue_instr_1, 32'h0031_02B3);
        @(posedge clk); #1 idle1 = 0;
        @(negedge clk);
        check("a_boot1", boot1, 1);
        check("a_boot2", boot2, 0);
        check("a_regnum", register_num, 5);
        @(posedge clk); #1;
        @(negedge clk);
        check("a_boot1_off", boot1, 0);
        check("a_count0", fifo_count, 0);
        check("a_valid_off", issue_valid_1, 0);

        // dependent pair: shadow covers the cycle before the table catches up
        do_reset();
        push(32'h1111, 5, 0, 0, 0);
        push(32'h2222, 6, 5, 0, 0);
        wait_offer(1, 5, "b_offer1");
        @(posedge clk); #1 idle1 = 0;
        @(negedge clk);
        check("b_boot1", boot1, 1);
        check("b_regnum5", register_num, 5);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            tbl = (c >= 2 && c <= 5) ? 32'h20 : 32'h0;
            @(negedge clk);
            check($sformatf("b_hold%0d", c), {issue_valid_1, issue_valid_2}, 0);
        end
        wait_offer(2, 4, "b_offer2");
        check("b_instr2", issue_instr_2, 32'h2222);
        @(posedge clk); #1 idle2 = 0;
        @(negedge clk);
        check("b_boot2", boot2, 1);
        check("b_boot1_quiet", boot1, 0);
        check("b_regnum6", register_num, 6);

        // rd=0 is issued without a claim pulse
        do_reset();
        push(32'h3333, 0, 4, 0, 0);
        wait_offer(1, 5, "d_offer");
        @(posedge clk); #1 idle1 = 0;
        @(negedge clk);
        check("d_no_boot", {boot1, boot2}, 0);
        check("d_regnum", register_num, 0);
        @(negedge clk);
        check("d_popped", fifo_count, 0);

        // ra only goes to processor 1
        do_reset();
        idle1 = 0;
        push(32'h4444, 1, 2, 0, 0);
        repeat (3) @(negedge clk);
        check("e_wait", {issue_valid_1, issue_valid_2}, 0);
        @(posedge clk); #1 idle1 = 1;
        wait_offer(1, 4, "e_offer1");

        // full FIFO, ignored push, reset during offer
        do_reset();
        idle1 = 0; idle2 = 0;
        for (int i = 0; i < 5; i++) push(32'h5000 + 32'(i), 5'(i + 8), 0, 0, 0);
        @(negedge clk);
        check("c_count4", fifo_count, 4);
        check("c_not_ready", in_ready, 0);
        @(posedge clk); #1 idle1 = 1;
        wait_offer(1, 4, "c_offer");
        check("c_head", issue_instr_1, 32'h5000);
        rst_n = 0;
        #1;
        check("c_rst_valid", {issue_valid_1, issue_valid_2, boot1, boot2}, 0);
        check("c_rst_instr", issue_instr_1 | issue_instr_2, 0);
        check("c_rst_regnum", register_num, 0);
        check("c_rst_count", fifo_count, 0);
        check("c_rst_ready", in_ready, 1);
        idle1 = 1; idle2 = 1;
        @(posedge clk); #1 rst_n = 1;
        repeat (3) @(negedge clk);
        check("c_discarded", {issue_valid_1, issue_valid_2}, 0);

        // randomized run against the issue-rule model
        do_reset();
        q.delete();
        pt1 = 0; pt2 = 0; issued = 0;
        foreach (ttim[r]) ttim[r] = 0;
        tbl_h1 = 0; i1_h1 = 1; i1_h2 = 1; i2_h1 = 1; sp_h1 = 0;
        bv_h1 = 0; bv_h2 = 0; br_h1 = 0; br_h2 = 0; pv = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if (issue_valid_1 && idle1 && $urandom_range(2) == 0) begin idle1 = 0; pt1 = $urandom_range(5, 1); end
            else if (pt1 > 0) begin pt1--; idle1 = pt1 == 0; end
            if (issue_valid_2 && idle2 && $urandom_range(2) == 0) begin idle2 = 0; pt2 = $urandom_range(5, 1); end
            else if (pt2 > 0) begin pt2--; idle2 = pt2 == 0; end
            for (int r = 0; r < 32; r++) if (ttim[r] > 0) ttim[r]--;
            if (c < 3600 && $urandom_range(15) == 0) ttim[$urandom_range(7)] = $urandom_range(4, 2);
            for (int r = 0; r < 32; r++) tbl[r] = ttim[r] > 0;
            sync_proc = 1'($urandom_range(1));
            in_valid = c < 3600 && $urandom_range(2) != 0;
            in_instr = $urandom; in_rd = 5'($urandom_range(7)); in_rs1 = 5'($urandom_range(7));
            in_rs2 = 5'($urandom_range(7)); in_sync = $urandom_range(9) == 0;
            @(negedge clk);
            e = q.size() != 0 ? q[0] : '{0, 0, 0, 0, 0};
            check("r_count", fifo_count, q.size());
            check("r_ready", in_ready, 32'(q.size() < FD));
            check("r_one_offer", 32'(issue_valid_1 && issue_valid_2), 0);
            if (issue_valid_1 || issue_valid_2) begin
                check("r_offer_nonempty", 32'(q.size() != 0), 1);
                check("r_offer_instr", issue_valid_1 ? issue_instr_1 : issue_instr_2, e.instr);
                if (!pv) begin
                    check("r_hazard", 32'(haz(e.rd, tbl_h1, bv_h2, br_h2) || haz(e.rs1, tbl_h1, bv_h2, br_h2)
                                       || haz(e.rs2, tbl_h1, bv_h2, br_h2)), 0);
                    if (e.sync) begin
                        check("r_barrier_proc", issue_valid_1, 1);
                        check("r_barrier_cond", 32'(sp_h1 && i1_h1 && i2_h1 && tbl_h1 == 0 && !bv_h2), 1);
                    end else if (issue_valid_2) begin
                        check("r_ra_proc1", 32'(e.rd == 1), 0);
                        check("r_proc1_unavail", 32'(i1_h1 && i1_h2), 0);
                    end else
                        check("r_proc1_avail", 32'(i1_h1 && i1_h2), 1);
                end
            end
            a1 = issue_valid_1 && !idle1;
            a2 = issue_valid_2 && !idle2;
            check("r_boot1", boot1, 32'(a1 && e.rd != 0));
            check("r_boot2", boot2, 32'(a2 && e.rd != 0));
            check("r_regnum", register_num, (a1 || a2) && e.rd != 0 ? 32'(e.rd) : 0);
            push_ok = in_valid && q.size() < FD;
            if (a1 || a2) begin
                void'(q.pop_front());
                issued++;
                if (e.rd != 0) ttim[e.rd] = $urandom_range(6, 2);
            end
            if (push_ok) q.push_back('{in_instr, in_rd, in_rs1, in_rs2, in_sync});
            i1_h2 = i1_h1; i1_h1 = idle1; i2_h1 = idle2; sp_h1 = sync_proc; tbl_h1 = tbl;
            bv_h2 = bv_h1; br_h2 = br_h1; bv_h1 = (a1 || a2) && e.rd != 0; br_h1 = e.rd;
            pv = issue_valid_1 || issue_valid_2;
        end
        check("r_drained", q.size(), 0);
        check("r_progress", 32'(issued >= 50), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
